rs_age_select: RTL and testbench

//  Parametrised reservation station for any functional unit (ALU, BRA, MUL, ...) in the Tomasulo core.

---
 rtl/rs_age_select_if.sv | 43 ++++
 rtl/rs_age_select.sv | 234 +++++++++++++++++++++++
 tb/tb_rs_age_select.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs_age_select_if.sv
// rtl/rs_age_select_if.sv - issue and dispatch handshake bundle for rs_age_select
//
// Ports (signals carried by the bundle):
//   issue_we / issue_ready            issue request and acceptance (!full)
//   Op_in, Vj_in, Vk_in, Qj_in, Qk_in issued opcode, operand values and producer tags
//   Extra_in, Dest_in                 pass-through payload and destination ROB tag
//   disp_valid / disp_ready           registered dispatch stage handshake
//   Op_out, Vj_out, Vk_out, Extra_out, Dest_out  dispatched op
// master = issue stage / functional unit side, slave = reservation station.
interface rs_age_select_if #(
    parameter int OP_W    = 4,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 4,
    parameter int EXTRA_W = 64
);
    logic               issue_we;
    logic               issue_ready;
    logic [OP_W-1:0]    Op_in;
    logic [DATA_W-1:0]  Vj_in;
    logic [DATA_W-1:0]  Vk_in;
    logic [TAG_W-1:0]   Qj_in;
    logic [TAG_W-1:0]   Qk_in;
    logic [EXTRA_W-1:0] Extra_in;
    logic [TAG_W-1:0]   Dest_in;

    logic               disp_valid;
    logic               disp_ready;
    logic [OP_W-1:0]    Op_out;
    logic [DATA_W-1:0]  Vj_out;
    logic [DATA_W-1:0]  Vk_out;
    logic [EXTRA_W-1:0] Extra_out;
    logic [TAG_W-1:0]   Dest_out;

    modport master (
        output issue_we, Op_in, Vj_in, Vk_in, Qj_in, Qk_in, Extra_in, Dest_in, disp_ready,
        input  issue_ready, disp_valid, Op_out, Vj_out, Vk_out, Extra_out, Dest_out
    );

    modport slave (
        input  issue_we, Op_in, Vj_in, Vk_in, Qj_in, Qk_in, Extra_in, Dest_in, disp_ready,
        output issue_ready, disp_valid, Op_out, Vj_out, Vk_out, Extra_out, Dest_out
    );
endinterface

// File: rtl/rs_age_select.sv
// rtl/rs_age_select.sv - age-ordered reservation station with registered dispatch stage
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous reset, active-high (priority over rollback)
//   rollback  synchronous flush of all entries and the dispatch stage
//   cdb_tag   NCDB broadcast tags, channel c at [c*TAG_W+:TAG_W], 0 = idle
//   cdb_data  NCDB broadcast values, channel c at [c*DATA_W+:DATA_W]
//   count     number of occupied entries
//   rs        issue / dispatch bundle (rs_age_select_if.slave)
module rs_age_select #(
    parameter int ENTRIES = 4,
    parameter int OP_W    = 4,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 4,
    parameter int NCDB    = 3,
    parameter int EXTRA_W = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rollback,
    input  logic [NCDB*TAG_W-1:0]         cdb_tag,
    input  logic [NCDB*DATA_W-1:0]        cdb_data,
    output logic [$clog2(ENTRIES+1)-1:0]  count,
    rs_age_select_if.slave                rs
);
    localparam int RANK_W = $clog2(ENTRIES);
    localparam int CNT_W  = $clog2(ENTRIES + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ENTRIES);

    // Entry storage
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [OP_W-1:0]    op_q    [ENTRIES];
    logic [OP_W-1:0]    op_d    [ENTRIES];
    logic [DATA_W-1:0]  vj_q    [ENTRIES];
    logic [DATA_W-1:0]  vj_d    [ENTRIES];
    logic [DATA_W-1:0]  vk_q    [ENTRIES];
    logic [DATA_W-1:0]  vk_d    [ENTRIES];
    logic [TAG_W-1:0]   qj_q    [ENTRIES];
    logic [TAG_W-1:0]   qj_d    [ENTRIES];
    logic [TAG_W-1:0]   qk_q    [ENTRIES];
    logic [TAG_W-1:0]   qk_d    [ENTRIES];
    logic [EXTRA_W-1:0] extra_q [ENTRIES];
    logic [EXTRA_W-1:0] extra_d [ENTRIES];
    logic [TAG_W-1:0]   dest_q  [ENTRIES];
    logic [TAG_W-1:0]   dest_d  [ENTRIES];
    logic [RANK_W-1:0]  rank_q  [ENTRIES];
    logic [RANK_W-1:0]  rank_d  [ENTRIES];

    logic [CNT_W-1:0]   count_q, count_d;

    // Dispatch stage
    logic               disp_valid_q, disp_valid_d;
    logic [OP_W-1:0]    op_out_q, op_out_d;
    logic [DATA_W-1:0]  vj_out_q, vj_out_d;
    logic [DATA_W-1:0]  vk_out_q, vk_out_d;
    logic [EXTRA_W-1:0] extra_out_q, extra_out_d;
    logic [TAG_W-1:0]   dest_out_q, dest_out_d;

    // Selection / allocation
    logic [ENTRIES-1:0] sel_oh;
    logic               sel_found;
    logic [RANK_W-1:0]  sel_rank;
    logic [ENTRIES-1:0] alloc_oh;
    logic               alloc_found;
    logic               load_en;
    logic               issue_acc;
    logic [RANK_W-1:0]  new_rank;

    // Returns {tag, value} after snooping the CDB. Channels are scanned from the
    // highest index down so the lowest matching channel is the last writer.
    // A zero tag never matches, so an already-valid operand passes through.
    function automatic logic [TAG_W+DATA_W-1:0] snoop(
        input logic [TAG_W-1:0]       q,
        input logic [DATA_W-1:0]      v,
        input logic [NCDB*TAG_W-1:0]  tags,
        input logic [NCDB*DATA_W-1:0] datas
    );
        logic [TAG_W-1:0]  q_r;
        logic [DATA_W-1:0] v_r;
        q_r = q;
        v_r = v;
        for (int c = NCDB - 1; c >= 0; c--) begin
            if ((tags[c*TAG_W +: TAG_W] != '0) && (tags[c*TAG_W +: TAG_W] == q)) begin
                q_r = '0;
                v_r = datas[c*DATA_W +: DATA_W];
            end
        end
        return {q_r, v_r};
    endfunction

    // Oldest ready entry: ranks of valid entries are unique, so the strict
    // compare yields exactly one winner.
    always_comb begin
        sel_found = 1'b0;
        sel_rank  = '0;
        sel_oh    = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0) &&
                (!sel_found || (rank_q[i] < sel_rank))) begin
                sel_found = 1'b1;
                sel_rank  = rank_q[i];
                sel_oh    = '0;
                sel_oh[i] = 1'b1;
            end
        end
    end

    // Lowest-index free slot, from registered state only: a slot freed by a
    // dispatch this cycle is not reused until the next cycle.
    always_comb begin
        alloc_found = 1'b0;
        alloc_oh    = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!valid_q[i] && !alloc_found) begin
                alloc_found = 1'b1;
                alloc_oh[i] = 1'b1;
            end
        end
    end

    assign rs.issue_ready = (count_q < FULL_CNT);
    assign issue_acc      = rs.issue_we && rs.issue_ready && alloc_found;
    assign load_en        = (!disp_valid_q || rs.disp_ready) && sel_found;
    // The newcomer is youngest; when an older entry leaves at this edge the
    // survivors shift down by one, so the newcomer lands one lower too.
    assign new_rank       = RANK_W'(count_q - CNT_W'(load_en));

    always_comb begin
        valid_d      = valid_q;
        op_d         = op_q;
        vj_d         = vj_q;
        vk_d         = vk_q;
        qj_d         = qj_q;
        qk_d         = qk_q;
        extra_d      = extra_q;
        dest_d       = dest_q;
        rank_d       = rank_q;
        disp_valid_d = disp_valid_q;
        op_out_d     = op_out_q;
        vj_out_d     = vj_out_q;
        vk_out_d     = vk_out_q;
        extra_out_d  = extra_out_q;
        dest_out_d   = dest_out_q;

        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i]) begin
                {qj_d[i], vj_d[i]} = snoop(qj_q[i], vj_q[i], cdb_tag, cdb_data);
                {qk_d[i], vk_d[i]} = snoop(qk_q[i], vk_q[i], cdb_tag, cdb_data);
                if (load_en && (rank_q[i] > sel_rank)) begin
                    rank_d[i] = rank_q[i] - RANK_W'(1);
                end
            end
            if (load_en && sel_oh[i]) begin
                valid_d[i] = 1'b0;
            end
            if (issue_acc && alloc_oh[i]) begin
                valid_d[i] = 1'b1;
                op_d[i]    = rs.Op_in;
                extra_d[i] = rs.Extra_in;
                dest_d[i]  = rs.Dest_in;
                rank_d[i]  = new_rank;
                {qj_d[i], vj_d[i]} = snoop(rs.Qj_in, rs.Vj_in, cdb_tag, cdb_data);
                {qk_d[i], vk_d[i]} = snoop(rs.Qk_in, rs.Vk_in, cdb_tag, cdb_data);
            end
        end

        // The dispatch stage is never woken: its operands are complete.
        if (load_en) begin
            disp_valid_d = 1'b1;
            for (int i = 0; i < ENTRIES; i++) begin
                if (sel_oh[i]) begin
                    op_out_d    = op_q[i];
                    vj_out_d    = vj_q[i];
                    vk_out_d    = vk_q[i];
                    extra_out_d = extra_q[i];
                    dest_out_d  = dest_q[i];
                end
            end
        end else if (!disp_valid_q || rs.disp_ready) begin
            disp_valid_d = 1'b0;
        end

        count_d = count_q + CNT_W'(issue_acc) - CNT_W'(load_en);
    end

    always_ff @(posedge clk) begin
        if (rst || rollback) begin
            valid_q      <= '0;
            count_q      <= '0;
            disp_valid_q <= 1'b0;
            op_out_q     <= '0;
            vj_out_q     <= '0;
            vk_out_q     <= '0;
            extra_out_q  <= '0;
            dest_out_q   <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                op_q[i]    <= '0;
                vj_q[i]    <= '0;
                vk_q[i]    <= '0;
                qj_q[i]    <= '0;
                qk_q[i]    <= '0;
                extra_q[i] <= '0;
                dest_q[i]  <= '0;
                rank_q[i]  <= '0;
            end
        end else begin
            valid_q      <= valid_d;
            op_q         <= op_d;
            vj_q         <= vj_d;
            vk_q         <= vk_d;
            qj_q         <= qj_d;
            qk_q         <= qk_d;
            extra_q      <= extra_d;
            dest_q       <= dest_d;
            rank_q       <= rank_d;
            count_q      <= count_d;
            disp_valid_q <= disp_valid_d;
            op_out_q     <= op_out_d;
            vj_out_q     <= vj_out_d;
            vk_out_q     <= vk_out_d;
            extra_out_q  <= extra_out_d;
            dest_out_q   <= dest_out_d;
        end
    end

    assign count        = count_q;
    assign rs.disp_valid = disp_valid_q;
    assign rs.Op_out     = op_out_q;
    assign rs.Vj_out     = vj_out_q;
    assign rs.Vk_out     = vk_out_q;
    assign rs.Extra_out  = extra_out_q;
    assign rs.Dest_out   = dest_out_q;
endmodule

// File: tb/tb_rs_age_select.sv
// tb/tb_rs_age_select.sv - randomized and directed bench for rs_age_select
module tb_rs_age_select;
    logic        clk = 1'b0;
    logic        rst;
    logic        rollback;
    logic [11:0] cdb_tag;
    logic [95:0] cdb_data;
    logic [2:0]  count;

    rs_age_select_if #(.OP_W(4), .DATA_W(32), .TAG_W(4), .EXTRA_W(64)) ifc ();

    rs_age_select #(
        .ENTRIES(4), .OP_W(4), .DATA_W(32), .TAG_W(4), .NCDB(3), .EXTRA_W(64)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rollback (rollback),
        .cdb_tag  (cdb_tag),
        .cdb_data (cdb_data),
        .count    (count),
        .rs       (ifc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] vj;
        logic [31:0] vk;
        logic [3:0]  qj;
        logic [3:0]  qk;
        logic [63:0] extra;
        logic [3:0]  dest;
    } ent_t;

    // Reference: queue kept in age order (front = oldest) plus the output stage.
    ent_t mq[$];
    logic m_dv;
    ent_t m_out;

    int n_vec = 0;
    int n_bad = 0;
    bit rec_en = 1'b0;
    logic [3:0] rec_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Lowest channel wins: stop at the first match.
    function automatic void wake(inout logic [3:0] q, inout logic [31:0] v);
        if (q == 4'd0) return;
        for (int c = 0; c < 3; c++) begin
            if (cdb_tag[c*4 +: 4] == q) begin
                v = cdb_data[c*32 +: 32];
                q = 4'd0;
                return;
            end
        end
    endfunction

    task automatic model_step();
        bit   acc;
        int   pick;
        ent_t e;
        if (rst || rollback) begin
            mq.delete();
            m_dv  = 1'b0;
            m_out = '0;
            return;
        end
        acc  = ifc.issue_we && (mq.size() < 4);
        pick = -1;
        if (!m_dv || ifc.disp_ready) begin
            for (int i = 0; i < mq.size(); i++) begin
                if (mq[i].qj == 4'd0 && mq[i].qk == 4'd0) begin
                    pick = i;
                    break;
                end
            end
            if (pick >= 0) begin
                m_out = mq[pick];
                m_dv  = 1'b1;
            end else begin
                m_dv = 1'b0;
            end
        end
        for (int i = 0; i < mq.size(); i++) begin
            e = mq[i];
            wake(e.qj, e.vj);
            wake(e.qk, e.vk);
            mq[i] = e;
        end
        if (pick >= 0) mq.delete(pick);
        if (acc) begin
            e.op    = ifc.Op_in;
            e.vj    = ifc.Vj_in;
            e.vk    = ifc.Vk_in;
            e.qj    = ifc.Qj_in;
            e.qk    = ifc.Qk_in;
            e.extra = ifc.Extra_in;
            e.dest  = ifc.Dest_in;
            wake(e.qj, e.vj);
            wake(e.qk, e.vk);
            mq.push_back(e);
        end
    endtask

    task automatic compare();
        check("disp_valid",  ifc.disp_valid,  m_dv);
        check("issue_ready", ifc.issue_ready, (mq.size() < 4));
        check("count",       count,           mq.size());
        check("Op_out",      ifc.Op_out,      m_out.op);
        check("Vj_out",      ifc.Vj_out,      m_out.vj);
        check("Vk_out",      ifc.Vk_out,      m_out.vk);
        check("Extra_out",   ifc.Extra_out,   m_out.extra);
        check("Dest_out",    ifc.Dest_out,    m_out.dest);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare();
        if (rec_en && ifc.disp_valid) rec_q.push_back(ifc.Dest_out);
    endtask

    task automatic idle();
        ifc.issue_we = 1'b0;
        ifc.Op_in    = '0;
        ifc.Vj_in    = '0;
        ifc.Vk_in    = '0;
        ifc.Qj_in    = '0;
        ifc.Qk_in    = '0;
        ifc.Extra_in = '0;
        ifc.Dest_in  = '0;
        cdb_tag      = '0;
        cdb_data     = '0;
        rollback     = 1'b0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] vj, input logic [31:0] vk,
                         input logic [3:0] qj, input logic [3:0] qk, input logic [3:0] dest);
        ifc.issue_we = 1'b1;
        ifc.Op_in    = op;
        ifc.Vj_in    = vj;
        ifc.Vk_in    = vk;
        ifc.Qj_in    = qj;
        ifc.Qk_in    = qk;
        ifc.Extra_in = {$urandom, $urandom};
        ifc.Dest_in  = dest;
    endtask

    initial begin
        m_dv  = 1'b0;
        m_out = '0;
        idle();
        ifc.disp_ready = 1'b1;

        // Reset held two cycles
        rst = 1'b1;
        cycle();
        cycle();
        check("rst_count",       count,          0);
        check("rst_disp_valid",  ifc.disp_valid, 0);
        check("rst_issue_ready", ifc.issue_ready, 1);
        check("rst_dest_out",    ifc.Dest_out,   0);
        rst = 1'b0;

        // Age order: A waits on tag 3, B and C ready; wakeup after C is issued
        rec_en = 1'b1;
        issue(4'd1, 32'hA0, 32'hA1, 4'd3, 4'd0, 4'd1);
        cycle();
        issue(4'd2, 32'hB0, 32'hB1, 4'd0, 4'd0, 4'd2);
        cycle();
        issue(4'd3, 32'hC0, 32'hC1, 4'd0, 4'd0, 4'd3);
        cycle();
        idle();
        for (int k = 0; k < 6; k++) begin
            if (k == 1) begin
                cdb_tag  = 12'h003;
                cdb_data = {64'd0, 32'h0000_1234};
            end else begin
                cdb_tag  = '0;
                cdb_data = '0;
            end
            cycle();
        end
        rec_en = 1'b0;
        check("age_n_disp", rec_q.size(), 3);
        check("age_first",  rec_q[0], 2);
        check("age_second", rec_q[1], 3);
        check("age_third",  rec_q[2], 1);

        // Issue bypass from CDB channel 2
        idle();
        cycle();
        issue(4'd5, 32'h1111, 32'h2222, 4'd5, 4'd0, 4'd4);
        cdb_tag  = {4'd5, 8'd0};
        cdb_data = {32'h0000_DEAD, 64'd0};
        cycle();
        idle();
        cycle();
        check("byp_disp_valid", ifc.disp_valid, 1);
        check("byp_vj_out",     ifc.Vj_out,     32'h0000_DEAD);
        check("byp_dest_out",   ifc.Dest_out,   4);
        cycle();
        cycle();

        // Full with backpressure: one op in the output stage plus four entries
        ifc.disp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            issue(4'd6, 32'(k), 32'(k + 16), 4'd0, 4'd0, 4'(5 + k));
            cycle();
        end
        issue(4'd7, 32'h77, 32'h78, 4'd0, 4'd0, 4'd10);
        cycle();
        check("full_issue_ready", ifc.issue_ready, 0);
        check("full_count",       count,           4);
        check("full_dest_out",    ifc.Dest_out,    5);
        idle();
        cycle();
        check("stall_dest_out",   ifc.Dest_out,    5);
        ifc.disp_ready = 1'b1;
        cycle();
        ifc.disp_ready = 1'b0;
        check("drain_count",       count,           3);
        check("drain_issue_ready", ifc.issue_ready, 1);
        check("drain_dest_out",    ifc.Dest_out,    6);

        // Rollback while stalled, together with an issue
        issue(4'd8, 32'h88, 32'h89, 4'd0, 4'd0, 4'd11);
        rollback = 1'b1;
        cycle();
        idle();
        check("rb_count",      count,          0);
        check("rb_disp_valid", ifc.disp_valid, 0);
        ifc.disp_ready = 1'b1;
        cycle();
        cycle();
        check("rb_absent_count", count,          0);
        check("rb_absent_valid", ifc.disp_valid, 0);

        // Two CDB channels wake both operands in the same cycle
        issue(4'd9, 32'h0, 32'h0, 4'd2, 4'd6, 4'd12);
        cycle();
        idle();
        cdb_tag  = {4'd0, 4'd2, 4'd6};
        cdb_data = {32'd0, 32'h0000_0022, 32'h0000_0066};
        cycle();
        idle();
        cycle();
        check("mcdb_disp_valid", ifc.disp_valid, 1);
        check("mcdb_vj_out",     ifc.Vj_out,     32'h22);
        check("mcdb_vk_out",     ifc.Vk_out,     32'h66);
        check("mcdb_dest_out",   ifc.Dest_out,   12);

        // Randomized traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            idle();
            rollback       = ($urandom_range(63) == 0);
            ifc.disp_ready = ($urandom_range(3) != 0);
            if ($urandom_range(1) == 1) begin
                issue(4'($urandom_range(15)), $urandom, $urandom,
                      ($urandom_range(1) == 1) ? 4'($urandom_range(7, 1)) : 4'd0,
                      ($urandom_range(1) == 1) ? 4'($urandom_range(7, 1)) : 4'd0,
                      4'($urandom_range(15)));
            end
            for (int c = 0; c < 3; c++) begin
                cdb_tag[c*4 +: 4]   = ($urandom_range(1) == 1) ? 4'($urandom_range(7, 1)) : 4'd0;
                cdb_data[c*32 +: 32] = $urandom;
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
